darkbus_ram_cons: RTL and testbench
===================================

// Module: darkbus_ram_cons
// PURPOSE
//   Consumer (responder) end of the darkbus interface. Serves initiator requests from a local
//   word-organised RAM window with a programmable number of wait states. Returns a one-cycle
//   VALID pulse per request, drives DATA on reads, honours byte enables on writes, and counts
//   accesses that fall outside its address window. Sits behind the core or a bus mux.
// PARAMETERS
//   AW           10            word-address bits; window size is 2**AW words (4 KB at default)
//   BASE         32'h0000_0000 window base; must be aligned to 2**(AW+2) bytes
//   WAIT_STATES  1             extra cycles before VALID; legal range 0..15
// PORTS
//   CLK      in     1   clock; all state updates on the rising edge
//   RES      in     1   synchronous reset, active-high
//   EN       in     1   request strobe from the initiator
//   RW       in     1   1 = read, 0 = write
//   BE       in     4   byte enables; BE[i] qualifies DATA[8i+7:8i] on writes
//   ADDR     in     32  byte address; ADDR[1:0] ignored
//   VALID    out    1   one-cycle response pulse
//   DATA     inout  32  write data in; read data out while this block responds
//   ERR_CNT  out    8   saturating count of out-of-window accesses
// BEHAVIOUR
//   Reset: RES high at an edge -> state IDLE, VALID=0, DATA released (high-Z), ERR_CNT=0.
//     RAM contents are not cleared. RES in any state aborts the pending request, and a
//     pending write is discarded.
//   States: IDLE, WAIT, RESP.
//   IDLE: if EN=1 at the edge, latch RW, BE, ADDR and DATA (write data) and load wcnt=WAIT_STATES.
//     Go to RESP if WAIT_STATES==0, otherwise go to WAIT. If EN=0, stay in IDLE.
//   WAIT: wcnt decrements each cycle. On the edge where wcnt==1, go to RESP.
//   RESP: VALID=1 for exactly this cycle, then unconditionally return to IDLE.
//   Latency: EN sampled at the end of cycle t -> VALID high in cycle t+1+WAIT_STATES.
//   Initiator contract: hold EN/RW/BE/ADDR/DATA stable through the VALID cycle.
//     The initiator may present a new request in the following cycle (the IDLE cycle).
//     EN still high in IDLE is treated as a new request. Peak rate: 1 access per WAIT_STATES+2 cycles.
//   Fields changing during WAIT or RESP are ignored, because the latched copies are used.
//   Hit test: ADDR[31:AW+2] == BASE[31:AW+2]. Word index = ADDR[AW+1:2].
//   Write hit: at the edge ending RESP, RAM[idx] byte i <= latched DATA byte i where BE[i]=1.
//     Bytes with BE[i]=0 are unchanged. BE=0 changes nothing but still returns VALID.
//   Read hit: RAM[idx] is fetched on entry to RESP (registered). DATA is driven with the full
//     32-bit word during RESP only. BE is ignored on reads.
//   Miss, read or write: no RAM change; a read returns 32'h0000_0000. VALID timing is identical
//     to a hit. ERR_CNT increments at the edge ending RESP and saturates at 8'hFF (no wrap).
//   DATA is driven only when state==RESP and latched RW==1; at all other times it is high-Z,
//     including during a write response.
//   A read and a write to the same word never overlap; no bypass logic is needed.
// TESTING
//   1) RES=1 for 2 cycles mid-idle -> VALID=0, DATA=Z, ERR_CNT=0.
//   2) Write, WAIT_STATES=1: addr 0x10, BE=F, data DEADBEEF -> VALID at t+2.
//      Then read 0x10 -> VALID at t+2 with DATA=DEADBEEF; DATA=Z one cycle before and after.
//   3) Byte write 0x10, BE=0010, data 0000AA00, then read 0x10 -> DEADAAEF.
//      Then write BE=0000, then read 0x10 -> still DEADAAEF.
//   4) Read 0x8000_0000 -> VALID at normal latency, DATA=0, ERR_CNT=1.
//      After 300 misses -> ERR_CNT=FF; RAM contents unchanged.
//   5) WAIT_STATES=0 -> EN held high with new fields every 2nd cycle gives VALID every 2nd cycle,
//      with correct data. WAIT_STATES=3 -> VALID at t+4.
//   6) RES pulsed during WAIT of a write of 12345678 to 0x20 -> no VALID, IDLE next cycle.
//      A subsequent read of 0x20 returns the old value.

Source files
------------

// File: rtl/darkbus_ram_cons.sv
// darkbus_ram_cons
//   Responder end of the darkbus interface. Requests that hit the local
//   word-organised RAM window are served after a fixed number of wait states.
//   Each request gets a one-cycle VALID pulse. Reads drive DATA during that
//   pulse. Writes honour byte enables. Accesses outside the window are answered
//   normally: reads return zero and writes are dropped. These accesses also
//   bump a saturating error counter.
//
// Parameters
//   AW          word-address bits, window is 2**AW words
//   BASE        window base byte address, aligned to 2**(AW+2)
//   WAIT_STATES extra cycles between request and VALID (0..15)
//
// Ports
//   CLK      clock, rising edge
//   RES      synchronous active-high reset
//   EN       request strobe
//   RW       1 = read, 0 = write
//   BE[3:0]  byte enables for writes
//   ADDR     byte address (bits 1:0 ignored)
//   VALID    one-cycle response pulse
//   DATA     write data in / read data out (driven only during a read response)
//   ERR_CNT  saturating count of out-of-window accesses
module darkbus_ram_cons #(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        EN,
  input  logic        RW,
  input  logic [3:0]  BE,
  input  logic [31:0] ADDR,
  output logic        VALID,
  inout  wire  [31:0] DATA,
  output logic [7:0]  ERR_CNT
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  wcnt;
  logic        rw_q;
  logic [3:0]  be_q;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  err_cnt;

  logic [31:0] mem [0:(1<<AW)-1];

  logic [31:2] fetch_addr;
  logic        fetch_hit;
  logic [AW-1:0] fetch_idx;
  logic        hit_q;
  logic [AW-1:0] idx_q;
  logic [1:0]  unused_addr_bits;

  assign unused_addr_bits = ADDR[1:0];

  // With zero wait states the RAM is fetched on the same edge that latches
  // the request, so the live address must be used while still in IDLE.
  assign fetch_addr = (state == ST_IDLE) ? ADDR[31:2] : addr_q;
  assign fetch_hit  = (fetch_addr[31:AW+2] == BASE[31:AW+2]);
  assign fetch_idx  = fetch_addr[AW+1:2];

  assign hit_q = (addr_q[31:AW+2] == BASE[31:AW+2]);
  assign idx_q = addr_q[AW+1:2];

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (EN) begin
          next_state = (WS == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt == 4'd1) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register, request latches, wait counter, read fetch and error count.
  // Read data is registered when entering RESP so that DATA is stable for the
  // whole response cycle.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state   <= ST_IDLE;
      wcnt    <= 4'd0;
      rw_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_cnt <= 8'd0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (EN) begin
            rw_q    <= RW;
            be_q    <= BE;
            addr_q  <= ADDR[31:2];
            wdata_q <= DATA;
            wcnt    <= WS;
          end
        end
        ST_WAIT: wcnt <= wcnt - 4'd1;
        ST_RESP: begin
          if (!hit_q && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
      if ((next_state == ST_RESP) && (state != ST_RESP)) begin
        rdata_q <= fetch_hit ? mem[fetch_idx] : 32'd0;
      end
    end
  end

  // RAM write at the edge ending a write response. RAM has no reset, and a
  // reset on that edge discards the write.
  always_ff @(posedge CLK) begin
    if (!RES && (state == ST_RESP) && !rw_q && hit_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign VALID   = (state == ST_RESP);
  assign ERR_CNT = err_cnt;
  assign DATA    = ((state == ST_RESP) && rw_q) ? rdata_q : 32'bz;

endmodule

// File: tb/tb_darkbus_ram_cons.sv
// Testbench for darkbus_ram_cons. Three instances with wait states 1, 0 and 3
// share one clock. Stimulus pushes expected responses into a per-instance
// queue. A monitor per instance pops and compares whenever VALID is seen.
// The data buses are pulled up, so a released bus reads as all ones.
module tb_darkbus_ram_cons;

  localparam int WS_A = 1;
  localparam int WS_B = 0;
  localparam int WS_C = 3;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  logic [2:0]  res   = 3'b111;
  logic [2:0]  en    = 3'b000;
  logic [2:0]  rw    = 3'b000;
  logic [2:0]  drive = 3'b000;
  logic [2:0]  mon_on = 3'b000;
  logic [3:0]  be   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];

  tri1 [31:0] bus0;
  tri1 [31:0] bus1;
  tri1 [31:0] bus2;
  wire        valid0, valid1, valid2;
  wire [7:0]  err0, err1, err2;

  assign bus0 = drive[0] ? wd[0] : 32'bz;
  assign bus1 = drive[1] ? wd[1] : 32'bz;
  assign bus2 = drive[2] ? wd[2] : 32'bz;

  darkbus_ram_cons #(.AW(10), .BASE(32'h0), .WAIT_STATES(WS_A)) u_dut0 (
    .CLK(clk), .RES(res[0]), .EN(en[0]), .RW(rw[0]), .BE(be[0]), .ADDR(addr[0]),
    .VALID(valid0), .DATA(bus0), .ERR_CNT(err0));
  darkbus_ram_cons #(.AW(10), .BASE(32'h0), .WAIT_STATES(WS_B)) u_dut1 (
    .CLK(clk), .RES(res[1]), .EN(en[1]), .RW(rw[1]), .BE(be[1]), .ADDR(addr[1]),
    .VALID(valid1), .DATA(bus1), .ERR_CNT(err1));
  darkbus_ram_cons #(.AW(10), .BASE(32'h0), .WAIT_STATES(WS_C)) u_dut2 (
    .CLK(clk), .RES(res[2]), .EN(en[2]), .RW(rw[2]), .BE(be[2]), .ADDR(addr[2]),
    .VALID(valid2), .DATA(bus2), .ERR_CNT(err2));

  function automatic int ws_of(input int k);
    case (k)
      0:       return WS_A;
      1:       return WS_B;
      default: return WS_C;
    endcase
  endfunction

  function automatic logic [31:0] rbus(input int k);
    case (k)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  function automatic logic vld(input int k);
    case (k)
      0:       return valid0;
      1:       return valid1;
      default: return valid2;
    endcase
  endfunction

  function automatic logic [7:0] errc(input int k);
    case (k)
      0:       return err0;
      1:       return err1;
      default: return err2;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request and hold it until VALID; the expected response is queued
  // for the monitor. With keep=1 EN stays high so the caller can chain the
  // next request into the following IDLE cycle.
  task automatic applyStimulus(input int k, input logic r, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_data, input logic keep);
    exp_t e;
    logic seen;
    e.is_read = r;
    e.data    = exp_data;
    e.cyc     = cyc + 1 + ws_of(k);
    qpush(k, e);
    en[k]    = 1'b1;
    rw[k]    = r;
    be[k]    = b;
    addr[k]  = a;
    wd[k]    = d;
    drive[k] = !r;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = vld(k);
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("[TB] FAIL valid_timeout dut%0d: got no VALID, required one by cycle %0d", k, e.cyc);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      en[k]    = 1'b0;
      drive[k] = 1'b0;
    end
  endtask

  // Monitor: compares every response against the queue and checks that the
  // bus is released whenever neither side should be driving it.
  task automatic mon(input int k);
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on[k]) begin
        if (vld(k)) begin
          if (qsize(k) == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_valid dut%0d: got VALID=1, required none (cycle %0d)", k, cyc);
          end else begin
            qpop(k, e);
            checkOutput($sformatf("latency dut%0d", k), 32'(cyc), 32'(e.cyc));
            if (e.is_read) begin
              checkOutput($sformatf("rdata dut%0d", k), rbus(k), e.data);
            end
          end
        end else if (!drive[k]) begin
          checkOutput($sformatf("released dut%0d", k), rbus(k), 32'hFFFF_FFFF);
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      be[k]   = 4'h0;
      addr[k] = 32'h0;
      wd[k]   = 32'h0;
    end
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none

    // Reset held two cycles on every instance
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset_valid dut%0d", k), 32'(vld(k)), 32'h0);
      checkOutput($sformatf("reset_data dut%0d", k), rbus(k), 32'hFFFF_FFFF);
      checkOutput($sformatf("reset_err dut%0d", k), 32'(errc(k)), 32'h0);
    end
    res = 3'b000;
    mon_on = 3'b111;
    @(posedge clk);
    #1;

    // Full-word write then read, one wait state
    applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // Single-byte write, then an all-disabled write that must change nothing
    applyStimulus(0, 1'b0, 4'b0010, 32'h10, 32'h0000_AA00, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0);
    applyStimulus(0, 1'b0, 4'b0000, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 4'b0000, 32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0);

    // Reset during the wait state of a write discards it
    applyStimulus(0, 1'b0, 4'hF, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0);
    en[0] = 1'b1; rw[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h20; wd[0] = 32'h1234_5678; drive[0] = 1'b1;
    @(posedge clk);
    #1;
    res[0] = 1'b1; en[0] = 1'b0; drive[0] = 1'b0;
    @(posedge clk);
    #1;
    res[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", 32'(valid0), 32'h0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 4'hF, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);
    checkOutput("err_before_miss", 32'(err0), 32'h0);

    // Out-of-window accesses
    applyStimulus(0, 1'b1, 4'hF, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    checkOutput("err_one_miss", 32'(err0), 32'h1);
    for (int n = 1; n < 300; n++) begin
      if (n % 2 == 0) begin
        applyStimulus(0, 1'b0, 4'hF, 32'h8000_0010, 32'h0BAD_0BAD, 32'h0, 1'b1);
      end else begin
        applyStimulus(0, 1'b1, 4'hF, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
      end
      if (n == 254) begin
        checkOutput("err_254", 32'(err0), 32'hFF);
      end
    end
    en[0] = 1'b0; drive[0] = 1'b0;
    checkOutput("err_saturated", 32'(err0), 32'hFF);
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0);

    // Mid-idle reset clears the counter but keeps RAM contents
    res[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_reset_err", 32'(err0), 32'h0);
    checkOutput("idle_reset_valid", 32'(valid0), 32'h0);
    res[0] = 1'b0;
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0);

    // Zero wait states, back-to-back requests every second cycle
    applyStimulus(1, 1'b0, 4'hF, 32'h40, 32'h1111_1111, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 4'hF, 32'h40, 32'h0, 32'h1111_1111, 1'b1);
    applyStimulus(1, 1'b0, 4'hF, 32'h44, 32'h2222_3333, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 4'hF, 32'h44, 32'h0, 32'h2222_3333, 1'b1);
    applyStimulus(1, 1'b0, 4'b1000, 32'h40, 32'hAB00_0000, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 4'hF, 32'h40, 32'h0, 32'hAB11_1111, 1'b0);

    // Three wait states
    applyStimulus(2, 1'b0, 4'hF, 32'h100, 32'hA5A5_5A5A, 32'h0, 1'b0);
    applyStimulus(2, 1'b1, 4'hF, 32'h100, 32'h0, 32'hA5A5_5A5A, 1'b0);
    applyStimulus(2, 1'b1, 4'hF, 32'h0000_1100, 32'h0, 32'h0, 1'b0);
    checkOutput("err_dut2", 32'(err2), 32'h1);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 32'(qsize(0) + qsize(1) + qsize(2)), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
